// File: rtl/lpc_io_target.sv
// LPC I/O target: decodes host I/O read/write cycles inside a 32-byte window and
// turns them into single-cycle register-file strobes, returning read data on LAD.
module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR = 16'h0800
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       LFRAME_N,
    input  logic [3:0] LAD_I,
    output logic [3:0] LAD_O,
    output logic       LAD_OE,
    input  logic [7:0] RdData,
    output logic [7:0] Addr,
    output logic       Wr,
    output logic [7:0] DataWrSW,
    output logic       Rd
);

    typedef enum logic [3:0] {
        IDLE, CYC, ADR3, ADR2, ADR1, ADR0, WD0, WD1,
        HTAR0, HTAR1, SYNC, RD0, RD1, TTAR0, TTAR1
    } lpcState_t;

    lpcState_t   stateReg, stateNext;
    logic        isWriteReg, isWriteNext;
    logic [11:0] addrShiftReg, addrShiftNext;
    logic [7:0]  addrReg, addrNext;
    logic [7:0]  dataWrReg, dataWrNext;
    logic [7:0]  rdDataReg, rdDataNext;

    logic [15:0] fullAddr;
    logic        addrMatch;
    logic [3:0]  ladOut;
    logic        ladOe;
    logic        wrStrobe;
    logic        rdStrobe;

    // The final address nibble is combined straight from the pins in ADR0.
    assign fullAddr  = {addrShiftReg, LAD_I};
    assign addrMatch = (fullAddr[15:5] == BASE_ADDR[15:5]);

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            stateReg     <= IDLE;
            isWriteReg   <= 1'b0;
            addrShiftReg <= 12'h000;
            addrReg      <= 8'h00;
            dataWrReg    <= 8'h00;
            rdDataReg    <= 8'h00;
        end else begin
            stateReg     <= stateNext;
            isWriteReg   <= isWriteNext;
            addrShiftReg <= addrShiftNext;
            addrReg      <= addrNext;
            dataWrReg    <= dataWrNext;
            rdDataReg    <= rdDataNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        isWriteNext   = isWriteReg;
        addrShiftNext = addrShiftReg;
        addrNext      = addrReg;
        dataWrNext    = dataWrReg;
        rdDataNext    = rdDataReg;
        ladOut        = 4'hF;
        ladOe         = 1'b0;
        wrStrobe      = 1'b0;
        rdStrobe      = 1'b0;

        // Pin outputs and strobes depend on the current state only.
        case (stateReg)
            HTAR1: rdStrobe = !isWriteReg;
            SYNC: begin
                ladOe    = 1'b1;
                ladOut   = 4'h0;
                wrStrobe = isWriteReg;
            end
            RD0: begin
                ladOe  = 1'b1;
                ladOut = rdDataReg[3:0];
            end
            RD1: begin
                ladOe  = 1'b1;
                ladOut = rdDataReg[7:4];
            end
            TTAR0: ladOe = 1'b1;
            default: ;
        endcase

        if (!LFRAME_N) begin
            // Framing always wins; a frame held low for several clocks restarts each time.
            stateNext = (LAD_I == 4'h0) ? CYC : IDLE;
        end else begin
            case (stateReg)
                IDLE: stateNext = IDLE;
                CYC: begin
                    if (LAD_I[3:2] == 2'b00) begin
                        stateNext   = ADR3;
                        isWriteNext = LAD_I[1];
                    end else begin
                        stateNext = IDLE;
                    end
                end
                ADR3: begin
                    addrShiftNext = {addrShiftReg[7:0], LAD_I};
                    stateNext     = ADR2;
                end
                ADR2: begin
                    addrShiftNext = {addrShiftReg[7:0], LAD_I};
                    stateNext     = ADR1;
                end
                ADR1: begin
                    addrShiftNext = {addrShiftReg[7:0], LAD_I};
                    stateNext     = ADR0;
                end
                ADR0: begin
                    if (addrMatch) begin
                        addrNext  = {3'b000, fullAddr[4:0]};
                        stateNext = isWriteReg ? WD0 : HTAR0;
                    end else begin
                        stateNext = IDLE;
                    end
                end
                WD0: begin
                    dataWrNext[3:0] = LAD_I;
                    stateNext       = WD1;
                end
                WD1: begin
                    dataWrNext[7:4] = LAD_I;
                    stateNext       = HTAR0;
                end
                HTAR0: stateNext = HTAR1;
                HTAR1: stateNext = SYNC;
                SYNC: begin
                    if (!isWriteReg) begin
                        rdDataNext = RdData;
                    end
                    stateNext = isWriteReg ? TTAR0 : RD0;
                end
                RD0:   stateNext = RD1;
                RD1:   stateNext = TTAR0;
                TTAR0: stateNext = TTAR1;
                TTAR1: stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    assign LAD_O    = ladOut;
    assign LAD_OE   = ladOe;
    assign Wr       = wrStrobe;
    assign Rd       = rdStrobe;
    assign Addr     = addrReg;
    assign DataWrSW = dataWrReg;

endmodule

// File: tb/tb_lpc_io_target.sv
// Directed vector bench for lpc_io_target: one host-driven clock per table record,
// outputs compared just after each rising edge, plus an async-reset corner sequence.
module tb_lpc_io_target;

    logic       LpcClock = 1'b0;
    logic       PciReset;
    logic       LFRAME_N;
    logic [3:0] LAD_I;
    logic [3:0] LAD_O;
    logic       LAD_OE;
    logic [7:0] RdData;
    logic [7:0] Addr;
    logic       Wr;
    logic [7:0] DataWrSW;
    logic       Rd;

    int testsRun  = 0;
    int testsFail = 0;

    typedef struct {
        string      name;
        logic       frameN;
        logic [3:0] lad;
        logic [7:0] rdData;
        logic       oe;
        logic [3:0] ladO;
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];

    lpc_io_target #(.BASE_ADDR(16'h0800)) dut (
        .LpcClock (LpcClock),
        .PciReset (PciReset),
        .LFRAME_N (LFRAME_N),
        .LAD_I    (LAD_I),
        .LAD_O    (LAD_O),
        .LAD_OE   (LAD_OE),
        .RdData   (RdData),
        .Addr     (Addr),
        .Wr       (Wr),
        .DataWrSW (DataWrSW),
        .Rd       (Rd)
    );

    always #15 LpcClock = ~LpcClock;

    task automatic add(input string n, input logic f, input logic [3:0] l, input logic [7:0] rdd,
                       input logic oe, input logic [3:0] lo, input logic wr, input logic rd,
                       input logic [7:0] a, input logic [7:0] d);
        vec_t t;
        t.name = n; t.frameN = f; t.lad = l; t.rdData = rdd;
        t.oe = oe; t.ladO = lo; t.wr = wr; t.rd = rd; t.addr = a; t.data = d;
        vecs.push_back(t);
    endtask

    task automatic checkNow(input string n, input int idx, input logic oe, input logic [3:0] lo,
                            input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d);
        testsRun++;
        if ({LAD_OE, LAD_O, Wr, Rd, Addr, DataWrSW} !== {oe, lo, wr, rd, a, d}) begin
            testsFail++;
            $display("FAIL %s[%0d]: got oe=%b lad=%h wr=%b rd=%b addr=%h data=%h, want oe=%b lad=%h wr=%b rd=%b addr=%h data=%h",
                     n, idx, LAD_OE, LAD_O, Wr, Rd, Addr, DataWrSW, oe, lo, wr, rd, a, d);
        end else begin
            $display("[TB] %s[%0d] ok: oe=%b lad=%h wr=%b rd=%b addr=%h data=%h",
                     n, idx, LAD_OE, LAD_O, Wr, Rd, Addr, DataWrSW);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        LFRAME_N = v.frameN;
        LAD_I    = v.lad;
        RdData   = v.rdData;
        @(posedge LpcClock);
        #1;
        checkNow(v.name, idx, v.oe, v.ladO, v.wr, v.rd, v.addr, v.data);
    endtask

    initial begin
        PciReset = 1'b0;
        LFRAME_N = 1'b1;
        LAD_I    = 4'hF;
        RdData   = 8'h00;
        repeat (3) @(posedge LpcClock);
        #1;
        checkNow("reset", 0, 1'b0, 4'hF, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge LpcClock);
        PciReset = 1'b1;

        // Write 0x081F <= 0x0F (data nibbles F,0 low first)
        add("wr", 0, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h00, 8'h00);
        add("wr", 1, 4'h2, 8'h00, 0, 4'hF, 0, 0, 8'h00, 8'h00);
        add("wr", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h00, 8'h00);
        add("wr", 1, 4'h8, 8'h00, 0, 4'hF, 0, 0, 8'h00, 8'h00);
        add("wr", 1, 4'h1, 8'h00, 0, 4'hF, 0, 0, 8'h00, 8'h00);
        add("wr", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h1F, 8'h00);
        add("wr", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h1F, 8'h0F);
        add("wr", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h1F, 8'h0F);
        add("wr", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h1F, 8'h0F);
        add("wr", 1, 4'hF, 8'h00, 1, 4'h0, 1, 0, 8'h1F, 8'h0F);
        add("wr", 1, 4'hF, 8'h00, 1, 4'hF, 0, 0, 8'h1F, 8'h0F);
        add("wr", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h1F, 8'h0F);
        add("wr", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h1F, 8'h0F);
        // Read 0x0803; RdData is valid only in the SYNC clock
        add("rd", 0, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h1F, 8'h0F);
        add("rd", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h1F, 8'h0F);
        add("rd", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h1F, 8'h0F);
        add("rd", 1, 4'h8, 8'h00, 0, 4'hF, 0, 0, 8'h1F, 8'h0F);
        add("rd", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h1F, 8'h0F);
        add("rd", 1, 4'h3, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("rd", 1, 4'hF, 8'h00, 0, 4'hF, 0, 1, 8'h03, 8'h0F);
        add("rd", 1, 4'hF, 8'h00, 1, 4'h0, 0, 0, 8'h03, 8'h0F);
        add("rd", 1, 4'hF, 8'h66, 1, 4'h6, 0, 0, 8'h03, 8'h0F);
        add("rd", 1, 4'hF, 8'h00, 1, 4'h6, 0, 0, 8'h03, 8'h0F);
        add("rd", 1, 4'hF, 8'h00, 1, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("rd", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("rd", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        // Write to 0x0900 lies outside the window
        add("miss", 0, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("miss", 1, 4'h2, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("miss", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("miss", 1, 4'h9, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("miss", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("miss", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("miss", 1, 4'h5, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("miss", 1, 4'hA, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("miss", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("miss", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        // Abort in WD1, then a clean write of 0xA5 to 0x0808
        add("abort", 0, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("abort", 1, 4'h2, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("abort", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("abort", 1, 4'h8, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("abort", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h03, 8'h0F);
        add("abort", 1, 4'h8, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h0F);
        add("abort", 1, 4'h5, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h05);
        add("abort", 0, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h05);
        add("abort", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h05);
        add("abort", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h05);
        add("abort", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h05);
        add("wr2", 0, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h05);
        add("wr2", 1, 4'h2, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h05);
        add("wr2", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h05);
        add("wr2", 1, 4'h8, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h05);
        add("wr2", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h05);
        add("wr2", 1, 4'h8, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h05);
        add("wr2", 1, 4'h5, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'h05);
        add("wr2", 1, 4'hA, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("wr2", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("wr2", 1, 4'hF, 8'h00, 1, 4'h0, 1, 0, 8'h08, 8'hA5);
        add("wr2", 1, 4'hF, 8'h00, 1, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("wr2", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("wr2", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        // Memory cycle (CYC=4) ignored, then 3-clock START and read of 0x0801
        add("mem", 0, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("mem", 1, 4'h4, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("mem", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("mem", 1, 4'h8, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("mem", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("mem", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("mem", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("start3", 0, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("start3", 0, 4'h5, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("start3", 0, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("start3", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("start3", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("start3", 1, 4'h8, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("start3", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h08, 8'hA5);
        add("start3", 1, 4'h1, 8'h00, 0, 4'hF, 0, 0, 8'h01, 8'hA5);
        add("start3", 1, 4'hF, 8'h00, 0, 4'hF, 0, 1, 8'h01, 8'hA5);
        add("start3", 1, 4'hF, 8'h00, 1, 4'h0, 0, 0, 8'h01, 8'hA5);
        add("start3", 1, 4'hF, 8'h3C, 1, 4'hC, 0, 0, 8'h01, 8'hA5);
        add("start3", 1, 4'hF, 8'h00, 1, 4'h3, 0, 0, 8'h01, 8'hA5);
        add("start3", 1, 4'hF, 8'h00, 1, 4'hF, 0, 0, 8'h01, 8'hA5);
        add("start3", 1, 4'hF, 8'h00, 0, 4'hF, 0, 0, 8'h01, 8'hA5);
        // Read of 0x0805 interrupted by reset while in RD0
        add("rst", 0, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h01, 8'hA5);
        add("rst", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h01, 8'hA5);
        add("rst", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h01, 8'hA5);
        add("rst", 1, 4'h8, 8'h00, 0, 4'hF, 0, 0, 8'h01, 8'hA5);
        add("rst", 1, 4'h0, 8'h00, 0, 4'hF, 0, 0, 8'h01, 8'hA5);
        add("rst", 1, 4'h5, 8'h00, 0, 4'hF, 0, 0, 8'h05, 8'hA5);
        add("rst", 1, 4'hF, 8'h00, 0, 4'hF, 0, 1, 8'h05, 8'hA5);
        add("rst", 1, 4'hF, 8'h00, 1, 4'h0, 0, 0, 8'h05, 8'hA5);
        add("rst", 1, 4'hF, 8'h5A, 1, 4'hA, 0, 0, 8'h05, 8'hA5);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Mid-RD0: the async reset must release LAD at once, not at the next edge.
        #4;
        PciReset = 1'b0;
        #1;
        checkNow("rst_async", 0, 1'b0, 4'hF, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge LpcClock);
        #1;
        checkNow("rst_hold", 0, 1'b0, 4'hF, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge LpcClock);
        PciReset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vec_t t;
            t.name = "rst_after"; t.frameN = 1'b1; t.lad = 4'hF; t.rdData = 8'h00;
            t.oe = 1'b0; t.ladO = 4'hF; t.wr = 1'b0; t.rd = 1'b0; t.addr = 8'h00; t.data = 8'h00;
            apply(t, i);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
